// File: rtl/mips_cpu_harvard_pc_sequencer_if.sv
// Fetch/PC sequencer bus.
// Bundles the transfer requests and the fetch-side outputs of the PC sequencer.
//   master : the decode/ALU side; drives the requests and observes the PC.
//   slave  : the sequencer itself.
// Signals:
//   clk_enable      global advance enable; 0 holds all sequencer state
//   stall           hold PC/state this cycle
//   branch_taken    conditional branch resolved taken; branch_offset = instr[15:0]
//   jump            J/JAL; jump_index = instr[25:0]
//   jump_reg        JR/JALR; jump_reg_target = rs value
//   instr_address   current PC
//   link_addr       PC+8
//   in_delay_slot   current instruction is a delay slot
//   active          1 while running
//   fault           sticky misaligned JR/JALR target
interface mips_cpu_harvard_pc_sequencer_if;
  logic        clk_enable;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic [31:0] instr_address;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;
  logic        fault;

  modport master (
    output clk_enable, stall, branch_taken, branch_offset, jump, jump_index,
           jump_reg, jump_reg_target,
    input  instr_address, link_addr, in_delay_slot, active, fault
  );

  modport slave (
    input  clk_enable, stall, branch_taken, branch_offset, jump, jump_index,
           jump_reg, jump_reg_target,
    output instr_address, link_addr, in_delay_slot, active, fault
  );
endinterface

// File: rtl/mips_cpu_harvard_pc_sequencer.sv
// Fetch/PC controller for the Harvard MIPS core.
// Owns the PC, branch-delay-slot sequencing, the halt condition and the active flag.
// Ports:
//   i_clk    core clock, rising edge
//   i_reset  synchronous reset, active-low (0 = reset)
//   io_bus   sequencer bus (slave side), see mips_cpu_harvard_pc_sequencer_if
// A transfer request taken in RUN latches its target, steps through one delay slot
// (DELAY) and then loads the target. A target equal to HALT_ADDR, or a misaligned
// JR/JALR target, stops the core in HALT until reset.
module mips_cpu_harvard_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic                           i_clk,
  input logic                           i_reset,
  mips_cpu_harvard_pc_sequencer_if.slave io_bus
);

  typedef enum logic [1:0] {StRun, StDelay, StHalt} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_active;
  logic        r_fault;

  state_e      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_target_next;
  logic        w_active_next;
  logic        w_fault_next;

  logic        w_adv;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  assign w_adv = io_bus.clk_enable & ~io_bus.stall & (r_state != StHalt);

  assign w_pc_plus4      = r_pc + 32'd4;
  // Word offset: sign-extend then scale by 4, relative to the delay-slot address.
  assign w_branch_target = w_pc_plus4 +
                           {{14{io_bus.branch_offset[15]}}, io_bus.branch_offset, 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], io_bus.jump_index, 2'b00};

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    w_active_next = r_active;
    w_fault_next  = r_fault;

    if (w_adv) begin
      unique case (r_state)
        StRun: begin
          w_pc_next = w_pc_plus4;
          if (io_bus.jump_reg) begin
            if (io_bus.jump_reg_target[1:0] != 2'b00) begin
              // Misaligned register target: stop before the delay slot runs.
              w_pc_next     = r_pc;
              w_fault_next  = 1'b1;
              w_active_next = 1'b0;
              w_state_next  = StHalt;
            end else begin
              w_target_next = io_bus.jump_reg_target;
              w_state_next  = StDelay;
            end
          end else if (io_bus.jump) begin
            w_target_next = w_jump_target;
            w_state_next  = StDelay;
          end else if (io_bus.branch_taken) begin
            w_target_next = w_branch_target;
            w_state_next  = StDelay;
          end
        end
        StDelay: begin
          // Requests from the delay-slot instruction are deliberately ignored.
          w_pc_next = r_target;
          if (r_target == HALT_ADDR) begin
            w_active_next = 1'b0;
            w_state_next  = StHalt;
          end else begin
            w_state_next  = StRun;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= StRun;
      r_pc     <= RESET_VECTOR;
      r_target <= 32'd0;
      r_active <= 1'b1;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
      r_active <= w_active_next;
      r_fault  <= w_fault_next;
    end
  end

  assign io_bus.instr_address = r_pc;
  assign io_bus.link_addr     = r_pc + 32'd8;
  assign io_bus.in_delay_slot = (r_state == StDelay);
  assign io_bus.active        = r_active;
  assign io_bus.fault         = r_fault;

endmodule

// File: tb/tb_mips_cpu_harvard_pc_sequencer.sv
// Directed bench for the PC sequencer: each step drives inputs, pushes the expected
// post-edge state to a scoreboard, clocks once and compares the popped entry.
module tb_mips_cpu_harvard_pc_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_cpu_harvard_pc_sequencer_if bus_if ();

  mips_cpu_harvard_pc_sequencer dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ds;
    logic        act;
    logic        flt;
  } exp_t;

  exp_t sb[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Push the expectation, advance one clock, then pop and compare away from the edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic ds,
                      input logic act, input logic flt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ds = ds; e.act = act; e.flt = flt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk32({e.tag, "_pc"},   bus_if.instr_address, e.pc);
      chk32({e.tag, "_link"}, bus_if.link_addr,     e.pc + 32'd8);
      chk1 ({e.tag, "_ds"},   bus_if.in_delay_slot, e.ds);
      chk1 ({e.tag, "_act"},  bus_if.active,        e.act);
      chk1 ({e.tag, "_flt"},  bus_if.fault,         e.flt);
    end
  endtask

  task automatic idle();
    bus_if.stall           = 1'b0;
    bus_if.branch_taken    = 1'b0;
    bus_if.branch_offset   = 16'h0;
    bus_if.jump            = 1'b0;
    bus_if.jump_index      = 26'h0;
    bus_if.jump_reg        = 1'b0;
    bus_if.jump_reg_target = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus_if.clk_enable = 1'b1;
    idle();

    // Reset and straight-line fetch
    step("rst", 32'hBFC00000, 0, 1, 0);
    reset = 1'b1;
    step("seq1", 32'hBFC00004, 0, 1, 0);
    step("seq2", 32'hBFC00008, 0, 1, 0);
    step("seq3", 32'hBFC0000C, 0, 1, 0);
    step("seq4", 32'hBFC00010, 0, 1, 0);

    // Backward branch; a jump in the delay slot must be ignored
    bus_if.branch_taken = 1'b1; bus_if.branch_offset = 16'hFFFC;
    step("br_ds", 32'hBFC00014, 1, 1, 0);
    idle();
    bus_if.jump = 1'b1; bus_if.jump_index = 26'h3FFFFFF;
    step("br_tgt", 32'hBFC00004, 0, 1, 0);
    idle();

    // Jump beats branch
    reset = 1'b0;
    step("rst2", 32'hBFC00000, 0, 1, 0);
    reset = 1'b1;
    bus_if.jump = 1'b1; bus_if.jump_index = 26'h0000100;
    bus_if.branch_taken = 1'b1; bus_if.branch_offset = 16'h0008;
    step("j_ds", 32'hBFC00004, 1, 1, 0);
    idle();
    step("j_tgt", 32'hB0000400, 0, 1, 0);

    // Jump-register beats jump
    bus_if.jump_reg = 1'b1; bus_if.jump_reg_target = 32'h00001000;
    bus_if.jump = 1'b1; bus_if.jump_index = 26'h0000200;
    step("jr_ds", 32'hB0000404, 1, 1, 0);
    idle();
    step("jr_tgt", 32'h00001000, 0, 1, 0);

    // Stall and clock-enable hold inside the delay slot
    bus_if.branch_taken = 1'b1; bus_if.branch_offset = 16'h0010;
    step("st_ds", 32'h00001004, 1, 1, 0);
    idle();
    bus_if.stall = 1'b1;
    step("st_h1", 32'h00001004, 1, 1, 0);
    step("st_h2", 32'h00001004, 1, 1, 0);
    step("st_h3", 32'h00001004, 1, 1, 0);
    bus_if.stall = 1'b0; bus_if.clk_enable = 1'b0;
    step("ce_h", 32'h00001004, 1, 1, 0);
    bus_if.clk_enable = 1'b1;
    step("st_tgt", 32'h00001044, 0, 1, 0);

    // PC wrap to zero without a transfer does not halt
    bus_if.jump_reg = 1'b1; bus_if.jump_reg_target = 32'hFFFFFFFC;
    step("wr_ds", 32'h00001048, 1, 1, 0);
    idle();
    step("wr_top", 32'hFFFFFFFC, 0, 1, 0);
    step("wr_zero", 32'h00000000, 0, 1, 0);
    step("wr_next", 32'h00000004, 0, 1, 0);

    // Transfer to HALT_ADDR halts after the delay slot
    bus_if.jump_reg = 1'b1; bus_if.jump_reg_target = 32'h00000000;
    step("h_ds", 32'h00000008, 1, 1, 0);
    idle();
    step("h_halt", 32'h00000000, 0, 0, 0);
    bus_if.jump = 1'b1; bus_if.jump_index = 26'h0000100;
    step("h_hold1", 32'h00000000, 0, 0, 0);
    idle();
    step("h_hold2", 32'h00000000, 0, 0, 0);

    // Reset out of HALT, then reset in DELAY discards the target
    reset = 1'b0;
    step("rst_h", 32'hBFC00000, 0, 1, 0);
    reset = 1'b1;
    bus_if.branch_taken = 1'b1; bus_if.branch_offset = 16'h0100;
    step("rd_ds", 32'hBFC00004, 1, 1, 0);
    idle();
    reset = 1'b0;
    step("rd_rst", 32'hBFC00000, 0, 1, 0);
    reset = 1'b1;
    step("rd_run", 32'hBFC00004, 0, 1, 0);

    // Misaligned JR target faults without running the delay slot
    bus_if.jump_reg = 1'b1; bus_if.jump_reg_target = 32'h00400002;
    step("f_set", 32'hBFC00004, 0, 0, 1);
    idle();
    step("f_hold", 32'hBFC00004, 0, 0, 1);
    reset = 1'b0;
    step("f_rst", 32'hBFC00000, 0, 1, 0);
    reset = 1'b1;
    bus_if.jump_reg = 1'b1; bus_if.jump_reg_target = 32'h00400001;
    step("f_bit0", 32'hBFC00000, 0, 0, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
